// File: rtl/sr_lsu_ctrl.sv
// Load/store sequencer between the schoolRISCV datapath and a handshaked data memory.
// One word-aligned transaction per access; the core stalls until it completes.
module sr_lsu_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        store_req,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  logic             store_act;
  logic             any_req;
  logic             bad_align;
  logic             req_err;
  logic             capture;
  logic             enter_err;
  logic             ack_ok;
  logic             time_out;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       type_q;
  logic [1:0]       off_q;
  logic             is_load_q;
  logic             err_mis_q;
  logic             err_to_q;
  logic [31:0]      rdata_q;
  logic [3:0]       store_be;
  logic [31:0]      store_data;
  logic [31:0]      shifted;
  logic [31:0]      load_ext;

  // Request validation: a store of size 0 is no request at all.
  always_comb begin
    store_act = store_req && (store_size != 2'd0);
    any_req   = load_req || store_act;
    bad_align = 1'b0;
    if (load_req) begin
      case (load_type)
        3'd0, 3'd4: bad_align = 1'b0;
        3'd1, 3'd5: bad_align = addr[0];
        3'd2:       bad_align = (addr[1:0] != 2'b00);
        default:    bad_align = 1'b1;
      endcase
    end else if (store_act) begin
      case (store_size)
        2'd2:    bad_align = addr[0];
        2'd3:    bad_align = (addr[1:0] != 2'b00);
        default: bad_align = 1'b0;
      endcase
    end
    req_err = bad_align || (load_req && store_act);
  end

  // Store lane steering: narrow data is replicated, byte enables pick the lanes.
  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata;
    case (store_size)
      2'd1: begin
        store_be   = 4'b0001 << addr[1:0];
        store_data = {4{wdata[7:0]}};
      end
      2'd2: begin
        store_be   = addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (type_q)
      3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {24'd0, shifted[7:0]};
      3'd5:    load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs; stall is forced low while reset is held.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    enter_err  = 1'b0;
    ack_ok     = 1'b0;
    time_out   = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          stall = 1'b1;
          if (req_err) begin
            enter_err  = 1'b1;
            state_next = DONE;
          end else begin
            capture    = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ack_ok     = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          time_out   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  assign misalign_err = done && err_mis_q;
  assign timeout_err  = done && err_to_q;
  assign rdata        = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      type_q    <= 3'd0;
      off_q     <= 2'd0;
      is_load_q <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      if (capture) begin
        cnt       <= '0;
        mem_we    <= !load_req;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= load_req ? 4'b1111 : store_be;
        mem_wdata <= load_req ? 32'd0 : store_data;
        type_q    <= load_type;
        off_q     <= addr[1:0];
        is_load_q <= load_req;
        err_mis_q <= 1'b0;
        err_to_q  <= 1'b0;
      end
      if (enter_err) begin
        err_mis_q <= 1'b1;
        err_to_q  <= 1'b0;
        rdata_q   <= 32'd0;
      end
      if (state == REQ) begin
        if (ack_ok) begin
          cnt     <= '0;
          rdata_q <= is_load_q ? load_ext : 32'd0;
        end else if (time_out) begin
          cnt      <= '0;
          err_to_q <= 1'b1;
          rdata_q  <= 32'd0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sr_lsu_ctrl.md
Name: sr_lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the schoolRISCV core datapath and a handshaked data memory.
- Accepts a decoded load or store (size and sign from the control decoder), drives one word-aligned memory transaction, and stalls the core until it completes.
- Aligns store data and byte enables, and extracts and extends load data.
- Flags misaligned accesses, conflicting requests and memory timeouts. The core routes these flags to its trap logic.

Parameters:
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before abort (1..255).
- CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_req  in  1  level; core executing load, held until done.
- store_req  in  1  level; core executing store, held until done.
- load_type  in  3  0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; others illegal.
- store_size  in  2  0=none, 1=byte, 2=half, 3=word.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rs2), low bits significant.
- stall  out  1  hold PC/pipeline this cycle.
- done  out  1  one-cycle pulse: access finished (ok or error).
- rdata  out  32  extended load result, valid when done=1 and load.
- misalign_err  out  1  one-cycle pulse with done.
- timeout_err  out  1  one-cycle pulse with done.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables (writes; 4'b1111 for reads).
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  completes the request; mem_rdata valid same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, counter 0, captured registers 0.
- FSM states: IDLE, REQ, DONE.
- IDLE, no request: stall=0, mem_req=0.
- IDLE, exactly one of load_req/store_req (store_req with store_size=0 counts as none): validate, then:
  - Error conditions: misaligned (half with addr[0]=1; word with addr[1:0]!=0), illegal load_type, or load_req and store_req both 1.
  - Error: go to DONE with err flag latched (misalign_err); stall=1 this cycle; no memory access ever issued.
  - No error: capture addr/type/size/wdata; stall=1; go to REQ.
- REQ: mem_req=1 with registered mem_we/mem_addr/mem_be/mem_wdata, all stable while in REQ. stall=1. Counter increments each cycle.
  - mem_ack=1: latch extracted data into rdata and go to DONE. Counter is cleared.
  - Counter reaches TIMEOUT without ack: drop mem_req and go to DONE with timeout_err latched. A mem_ack in that same cycle wins (normal completion).
- DONE: done=1, stall=0, error pulse if latched. rdata holds the load result; 0 for stores and errors. Next state is always IDLE; request inputs are ignored in DONE (core advances at end of DONE).
- Minimum latency with ack in first REQ cycle: IDLE to REQ to DONE = 3 cycles, 2 stalled.
- Store lanes:
  - byte: mem_be=1<<addr[1:0]; wdata[7:0] replicated to all 4 lanes.
  - half: mem_be=addr[1]?4'b1100:4'b0011; wdata[15:0] replicated to both halves.
  - word: mem_be=4'b1111.
- Load extract:
  - Shift mem_rdata right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as-is.
- rst asserted mid-REQ: mem_req drops immediately (async); the transaction is abandoned.

Test Plan:
- LW addr=0x100, mem_ack on the first REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'hF, we=0. done on cycle 3 with rdata=0xDEADBEEF. stall high exactly 2 cycles.
- LB addr=0x103, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80. Same access as LBU -> rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200. On ack, done=1 and rdata=0.
- LW addr=0x101 -> no mem_req ever. DONE next cycle with done=1, misalign_err=1. load_req with store_req=3 also gives misalign_err=1.
- SW with mem_ack never asserted -> mem_req high for TIMEOUT (15) cycles, then done=1 and timeout_err=1. mem_req=0 in DONE.
- rst pulsed during REQ -> mem_req, stall and done go to 0 immediately, state=IDLE. A following LW completes normally.
